// File: rtl/pipe_addsub_pkg.sv
// Shared defaults and configuration helpers for the pipelined adder/subtractor.
package pipe_addsub_pkg;

  localparam int PA_N_DEFAULT      = 16;
  localparam int PA_STAGES_DEFAULT = 4;

  function automatic bit pa_cfg_ok(input int n, input int stages);
    return (stages >= 1) && (stages <= n) && ((n % stages) == 0);
  endfunction

endpackage

// File: rtl/pipe_addsub_if.sv
// Operand/result handshake bundle; master is the environment, slave the datapath.
interface pipe_addsub_if
  import pipe_addsub_pkg::*;
#(
  parameter int N = PA_N_DEFAULT
);
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         cin;
  logic         sub;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] y;
  logic         cout;
  logic         ovf;

  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, y, cout, ovf
  );

  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, y, cout, ovf
  );
endinterface

// File: rtl/pipe_addsub_add_chunk.sv
// Combinational W-bit ripple chunk built from single-bit full adders.
// c_msb is the carry into the chunk MSB, needed for signed overflow on the top chunk.
module fullAdder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));
endmodule

module add_chunk
  import pipe_addsub_pkg::*;
#(
  parameter int W = PA_N_DEFAULT / PA_STAGES_DEFAULT
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout,
  output logic         c_msb
);
  logic [W:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < W; i++) begin : g_bit
    fullAdder u_fa (
      .a  (a[i]),
      .b  (b[i]),
      .ci (c[i]),
      .s  (sum[i]),
      .co (c[i+1])
    );
  end

  assign cout  = c[W];
  assign c_msb = c[W-1];
endmodule

// File: rtl/pipe_addsub.sv
// Carry-pipelined N-bit add/sub: chunk k is summed in stage k with the carry registered by stage k-1.
// Latency STAGES, one beat per cycle; the whole pipe stalls together when the output is held.
module pipe_addsub
  import pipe_addsub_pkg::*;
#(
  parameter int N      = PA_N_DEFAULT,
  parameter int STAGES = PA_STAGES_DEFAULT
) (
  input logic          clk,
  input logic          rst,
  pipe_addsub_if.slave io
);
  localparam int W = N / STAGES;

  if (!pa_cfg_ok(N, STAGES)) begin : g_bad_cfg
    $error("pipe_addsub: N must be a multiple of STAGES and 1 <= STAGES <= N");
  end

  logic         adv;
  logic [N-1:0] bi;
  logic         c0;

  logic [STAGES-1:0] v_q,   v_d;
  logic [N-1:0]      res_q [STAGES];
  logic [N-1:0]      res_d [STAGES];
  logic [N-1:0]      a_q   [STAGES];
  logic [N-1:0]      a_d   [STAGES];
  logic [N-1:0]      b_q   [STAGES];
  logic [N-1:0]      b_d   [STAGES];
  logic              c_q   [STAGES];
  logic              c_d   [STAGES];
  logic              ovf_q, ovf_d;

  logic [W-1:0] ch_a  [STAGES];
  logic [W-1:0] ch_b  [STAGES];
  logic [W-1:0] ch_s  [STAGES];
  logic         ch_ci [STAGES];
  logic         ch_co [STAGES];
  logic         ch_cm [STAGES];

  // Subtraction is a + ~b + ~cin, so cout=1 means no borrow.
  assign adv = ~v_q[STAGES-1] | io.out_ready;
  assign bi  = io.sub ? ~io.b : io.b;
  assign c0  = io.cin ^ io.sub;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    if (k == 0) begin : g_first
      assign ch_a[k]  = io.a[W-1:0];
      assign ch_b[k]  = bi[W-1:0];
      assign ch_ci[k] = c0;
    end else begin : g_next
      assign ch_a[k]  = a_q[k-1][k*W +: W];
      assign ch_b[k]  = b_q[k-1][k*W +: W];
      assign ch_ci[k] = c_q[k-1];
    end

    add_chunk #(.W(W)) u_add (
      .a     (ch_a[k]),
      .b     (ch_b[k]),
      .cin   (ch_ci[k]),
      .sum   (ch_s[k]),
      .cout  (ch_co[k]),
      .c_msb (ch_cm[k])
    );
  end

  always_comb begin
    v_d   = v_q;
    res_d = res_q;
    a_d   = a_q;
    b_d   = b_q;
    c_d   = c_q;
    ovf_d = ovf_q;
    if (adv) begin
      v_d[0]          = io.in_valid;
      a_d[0]          = io.a;
      b_d[0]          = bi;
      res_d[0]        = '0;
      res_d[0][W-1:0] = ch_s[0];
      c_d[0]          = ch_co[0];
      for (int k = 1; k < STAGES; k++) begin
        v_d[k]             = v_q[k-1];
        a_d[k]             = a_q[k-1];
        b_d[k]             = b_q[k-1];
        res_d[k]           = res_q[k-1];
        res_d[k][k*W +: W] = ch_s[k];
        c_d[k]             = ch_co[k];
      end
      ovf_d = ch_co[STAGES-1] ^ ch_cm[STAGES-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v_q   <= '0;
      ovf_q <= 1'b0;
      for (int k = 0; k < STAGES; k++) begin
        res_q[k] <= '0;
        a_q[k]   <= '0;
        b_q[k]   <= '0;
        c_q[k]   <= 1'b0;
      end
    end else begin
      v_q   <= v_d;
      res_q <= res_d;
      a_q   <= a_d;
      b_q   <= b_d;
      c_q   <= c_d;
      ovf_q <= ovf_d;
    end
  end

  assign io.in_ready  = adv;
  assign io.out_valid = v_q[STAGES-1];
  assign io.y         = res_q[STAGES-1];
  assign io.cout      = c_q[STAGES-1];
  assign io.ovf       = ovf_q;
endmodule

// File: tb/tb_pipe_addsub.sv
// Directed and randomised-backpressure bench for pipe_addsub (N=16, STAGES=4).
module tb_pipe_addsub;
  import pipe_addsub_pkg::*;

  localparam int N = 16;
  localparam int S = 4;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  int   pushes = 0;
  int   pops   = 0;
  logic [17:0] exp_q [$];

  pipe_addsub_if #(.N(N)) io ();

  pipe_addsub #(.N(N), .STAGES(S)) dut (
    .clk (clk),
    .rst (rst),
    .io  (io.slave)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk_b(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Packed as {ovf, cout, y}.
  task automatic chk_w(input string tag, input logic [17:0] obs, input logic [17:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed={ovf,cout,y}=0x%05h expected=0x%05h", tag, obs, exp);
    end
  endtask

  function automatic logic [17:0] model(input logic [15:0] a, input logic [15:0] b,
                                        input logic c, input logic s);
    logic [16:0] full;
    int          sr;
    if (!s) begin
      full = {1'b0, a} + {1'b0, b} + 17'(c);
      sr   = int'($signed(a)) + int'($signed(b)) + int'(c);
    end else begin
      full = {1'b0, a} + {1'b0, ~b} + 17'(!c);
      sr   = int'($signed(a)) - int'($signed(b)) - int'(c);
    end
    return {(sr > 32767) || (sr < -32768), full[16], full[15:0]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [15:0] a, input logic [15:0] b,
                       input logic c, input logic s, input logic ordy);
    io.in_valid  = v;
    io.a         = a;
    io.b         = b;
    io.cin       = c;
    io.sub       = s;
    io.out_ready = ordy;
  endtask

  task automatic sb_cycle();
    logic [17:0] got;
    #1;
    chk_b("rand_in_ready", io.in_ready, ~io.out_valid | io.out_ready);
    if (io.out_valid && io.out_ready) begin
      if (exp_q.size() == 0) begin
        chk_b("rand_extra_beat", io.out_valid, 1'b0);
      end else begin
        got = exp_q.pop_front();
        pops++;
        chk_w("rand_data", {io.ovf, io.cout, io.y}, got);
      end
    end
    if (io.in_valid && io.in_ready) begin
      exp_q.push_back(model(io.a, io.b, io.cin, io.sub));
      pushes++;
    end
    tick();
  endtask

  initial begin
    logic [15:0] i16;

    // Reset with a beat offered: nothing may be accepted.
    rst = 1'b1;
    drive(1'b1, 16'h1234, 16'h4321, 1'b0, 1'b0, 1'b1);
    tick();
    tick();
    chk_b("rst_out_valid", io.out_valid, 1'b0);
    chk_w("rst_outputs", {io.ovf, io.cout, io.y}, 18'h0);
    rst = 1'b0;
    drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1);
    #1;
    chk_b("rst_in_ready", io.in_ready, 1'b1);
    for (int k = 0; k < 5; k++) begin
      tick();
      chk_b("rst_no_beat", io.out_valid, 1'b0);
    end

    // Carry ripples across all four chunks; latency exactly 4.
    drive(1'b1, 16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b1);
    tick();
    io.in_valid = 1'b0;
    for (int k = 1; k < S; k++) begin
      chk_b("lat_early", io.out_valid, 1'b0);
      tick();
    end
    chk_b("lat_valid", io.out_valid, 1'b1);
    chk_w("full_carry", {io.ovf, io.cout, io.y}, {1'b0, 1'b1, 16'h0000});
    tick();
    chk_b("full_carry_once", io.out_valid, 1'b0);

    // Signed overflow in both directions, back to back.
    drive(1'b1, 16'h8000, 16'h0001, 1'b0, 1'b1, 1'b1);
    tick();
    drive(1'b1, 16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b1);
    tick();
    io.in_valid = 1'b0;
    tick();
    tick();
    chk_b("ovf_sub_valid", io.out_valid, 1'b1);
    chk_w("ovf_sub", {io.ovf, io.cout, io.y}, {1'b1, 1'b1, 16'h7FFF});
    tick();
    chk_w("ovf_add", {io.ovf, io.cout, io.y}, {1'b1, 1'b0, 16'h8000});
    // Borrow-in with borrow out: 0x0000 - 0x0000 - 1 = 0xFFFF, cout=0.
    drive(1'b1, 16'h0000, 16'h0000, 1'b1, 1'b1, 1'b1);
    tick();
    io.in_valid = 1'b0;
    tick();
    tick();
    tick();
    chk_w("borrow_in", {io.ovf, io.cout, io.y}, {1'b0, 1'b0, 16'hFFFF});
    tick();

    // Eight back-to-back beats, full throughput, in order.
    for (int j = 1; j <= 12; j++) begin
      if (j <= 8) begin
        i16 = 16'(j);
        drive(1'b1, i16, 16'(16'h0100 * i16), 1'b0, 1'b0, 1'b1);
        #1;
        chk_b("tput_in_ready", io.in_ready, 1'b1);
      end else begin
        io.in_valid = 1'b0;
      end
      tick();
      chk_b("tput_valid", io.out_valid, (j >= 4) && (j <= 11));
      if ((j >= 4) && (j <= 11)) begin
        i16 = 16'(j - 3);
        chk_w("tput_data", {io.ovf, io.cout, io.y}, {2'b00, 16'(16'h0101 * i16)});
      end
    end

    // Fill the pipe, then hold the output for 3 cycles.
    for (int k = 1; k <= 4; k++) begin
      i16 = 16'(k);
      drive(1'b1, 16'(16'h1111 * i16), 16'h0001, 1'b0, 1'b0, 1'b1);
      tick();
    end
    drive(1'b1, 16'h5555, 16'h0001, 1'b0, 1'b0, 1'b0);
    #1;
    chk_b("bp_in_ready_low", io.in_ready, 1'b0);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk_b("bp_hold_valid", io.out_valid, 1'b1);
      chk_w("bp_hold_data", {io.ovf, io.cout, io.y}, {2'b00, 16'h1112});
      chk_b("bp_hold_in_ready", io.in_ready, 1'b0);
    end
    io.out_ready = 1'b1;
    #1;
    chk_b("bp_release_ready", io.in_ready, 1'b1);
    tick();
    io.in_valid = 1'b0;
    chk_w("bp_drain1", {io.ovf, io.cout, io.y}, {2'b00, 16'h2223});
    tick();
    chk_w("bp_drain2", {io.ovf, io.cout, io.y}, {2'b00, 16'h3334});
    tick();
    chk_w("bp_drain3", {io.ovf, io.cout, io.y}, {2'b00, 16'h4445});
    tick();
    chk_b("bp_drain4_valid", io.out_valid, 1'b1);
    chk_w("bp_drain4", {io.ovf, io.cout, io.y}, {2'b00, 16'h5556});
    tick();
    chk_b("bp_empty", io.out_valid, 1'b0);

    // Random traffic and random back-pressure against the reference model.
    for (int k = 0; k < 300; k++) begin
      drive($urandom_range(0, 9) < 7, 16'($urandom()), 16'($urandom()),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            $urandom_range(0, 9) < 6);
      sb_cycle();
    end
    for (int k = 0; k < 20; k++) begin
      io.in_valid  = 1'b0;
      io.out_ready = 1'b1;
      sb_cycle();
    end
    chk_b("rand_drained", exp_q.size() == 0, 1'b1);
    chk_b("rand_count", pops == pushes, 1'b1);

    // Reset while three beats are in flight; none may ever appear.
    for (int k = 1; k <= 3; k++) begin
      i16 = 16'(k);
      drive(1'b1, 16'(16'h0F0F * i16), 16'h0101, 1'b0, 1'b0, 1'b1);
      tick();
    end
    rst = 1'b1;
    io.in_valid = 1'b0;
    tick();
    chk_b("midrst_valid", io.out_valid, 1'b0);
    chk_w("midrst_outputs", {io.ovf, io.cout, io.y}, 18'h0);
    rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      tick();
      chk_b("midrst_no_beat", io.out_valid, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
